// File: rtl/alu_sequencer.sv
// Command FIFO + 4-state issue/execute/collect sequencer in front of a combinational 4-bit ALU.
// Optional ALU_SEQ_CHAIN_EN: command bit 12 replaces operand A with the last captured result.
module alu_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic [12:0] ivCmd,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  output logic [3:0]  ovInstruccion,
  output logic [3:0]  ovRegistroA,
  output logic [3:0]  ovRegistroB,
  input  logic [3:0]  ivResultado,
  input  logic [3:0]  ivFlags,
  output logic [3:0]  ovResult,
  output logic [3:0]  ovFlagsOut,
  output logic        oResValid,
  input  logic        iResReady,
  output logic [7:0]  ovIssued
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, DONE} stateType;

  stateType    stateReg, stateNext;
  logic [12:0] cmdMem [FIFO_DEPTH];
  logic [AW:0] wrPtrReg, rdPtrReg;
  logic [12:0] headCmd;
  logic        fifoFull, fifoEmpty, push, pop, capture, resAccept;
  logic [3:0]  opcodeReg, aReg, bReg, resultReg, flagsReg;
  logic [7:0]  issuedReg;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifoEmpty = (wrPtrReg == rdPtrReg);
  assign fifoFull  = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                     (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
  assign oCmdReady = !fifoFull && iReset_n;
  assign push      = iCmdValid && oCmdReady;
  assign headCmd   = cmdMem[rdPtrReg[AW-1:0]];

  always_ff @(posedge iClk) begin
    if (push) cmdMem[wrPtrReg[AW-1:0]] <= ivCmd;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + PTR_ONE;
      if (pop)  rdPtrReg <= rdPtrReg + PTR_ONE;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) stateReg <= IDLE;
    else           stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    pop       = 1'b0;
    capture   = 1'b0;
    resAccept = 1'b0;
    case (stateReg)
      IDLE:  if (!fifoEmpty) stateNext = ISSUE;
      ISSUE: begin
        pop       = 1'b1;
        stateNext = EXEC;
      end
      EXEC: begin
        capture   = 1'b1;
        stateNext = DONE;
      end
      DONE: if (iResReady) begin
        resAccept = 1'b1;
        stateNext = fifoEmpty ? IDLE : ISSUE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef ALU_SEQ_CHAIN_EN
  logic [3:0] chainReg;
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)    chainReg <= '0;
    else if (capture) chainReg <= ivResultado;
  end
`else
  logic unusedChainBit;
  assign unusedChainBit = headCmd[12];
`endif

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      opcodeReg <= '0;
      aReg      <= '0;
      bReg      <= '0;
      resultReg <= '0;
      flagsReg  <= '0;
      issuedReg <= '0;
    end else begin
      if (pop) begin
        opcodeReg <= headCmd[11:8];
`ifdef ALU_SEQ_CHAIN_EN
        aReg      <= headCmd[12] ? chainReg : headCmd[7:4];
`else
        aReg      <= headCmd[7:4];
`endif
        bReg      <= headCmd[3:0];
      end
      // ALU had a full cycle of stable operands by the end of EXEC.
      if (capture) begin
        resultReg <= ivResultado;
        flagsReg  <= ivFlags;
      end
      if (resAccept) issuedReg <= issuedReg + 8'd1;
    end
  end

  assign ovInstruccion = opcodeReg;
  assign ovRegistroA   = aReg;
  assign ovRegistroB   = bReg;
  assign ovResult      = resultReg;
  assign ovFlagsOut    = flagsReg;
  assign oResValid     = (stateReg == DONE);
  assign ovIssued      = issuedReg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with an adder stub ALU and a command-level result model.
// Honours ALU_SEQ_CHAIN_EN the same way as the design build.
module tb_alu_sequencer;
  logic        iClk = 1'b0;
  logic        iReset_n;
  logic [12:0] ivCmd;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [3:0]  ovInstruccion, ovRegistroA, ovRegistroB;
  logic [3:0]  ivResultado, ivFlags, ovResult, ovFlagsOut;
  logic        oResValid, iResReady;
  logic [7:0]  ovIssued;
  logic        aluCarry;

  typedef struct {
    logic [3:0] op, a, b, res, flags;
  } expType;

  expType     expQ[$];
  logic [3:0] prevRes;
  logic [7:0] issuedModel;
  int         readyMode;
  int         nChecks = 0;
  int         nFails  = 0;

`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  alu_sequencer #(.FIFO_DEPTH(4)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .ivCmd(ivCmd), .iCmdValid(iCmdValid),
    .oCmdReady(oCmdReady), .ovInstruccion(ovInstruccion), .ovRegistroA(ovRegistroA),
    .ovRegistroB(ovRegistroB), .ivResultado(ivResultado), .ivFlags(ivFlags),
    .ovResult(ovResult), .ovFlagsOut(ovFlagsOut), .oResValid(oResValid),
    .iResReady(iResReady), .ovIssued(ovIssued)
  );

  always #5 iClk = ~iClk;

  assign {aluCarry, ivResultado} = {1'b0, ovRegistroA} + {1'b0, ovRegistroB};
  assign ivFlags = {3'b000, aluCarry};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void modelPush(input logic [12:0] c);
    expType e;
    logic [4:0] s;
    e.op    = c[11:8];
    e.b     = c[3:0];
    e.a     = (CHAIN && c[12]) ? prevRes : c[7:4];
    s       = {1'b0, e.a} + {1'b0, e.b};
    e.res   = s[3:0];
    e.flags = {3'b000, s[4]};
    prevRes = e.res;
    expQ.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic pushCmd(input logic [12:0] cmd);
    int w = 0;
    ivCmd     = cmd;
    iCmdValid = 1'b1;
    while (!oCmdReady && w < 300) begin
      @(negedge iClk);
      w++;
    end
    if (!oCmdReady) begin
      checkVal("push_ready", oCmdReady, 1);
      iCmdValid = 1'b0;
      return;
    end
    @(posedge iClk);
    modelPush(cmd);
    @(negedge iClk);
    iCmdValid = 1'b0;
  endtask

  task automatic waitResult(output logic [3:0] r, output logic [3:0] f);
    int w = 0;
    while (!oResValid && w < 50) begin
      @(negedge iClk);
      w++;
    end
    checkVal("res_wait", oResValid, 1);
    r = ovResult;
    f = ovFlagsOut;
    @(negedge iClk);
  endtask

  task automatic drain();
    int w = 0;
    while (expQ.size() != 0 && w < 3000) begin
      @(negedge iClk);
      w++;
    end
    checkVal("drain", expQ.size(), 0);
    repeat (2) @(negedge iClk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_instr"}, ovInstruccion, 0);
    checkVal({tag, "_regA"}, ovRegistroA, 0);
    checkVal({tag, "_regB"}, ovRegistroB, 0);
    checkVal({tag, "_result"}, ovResult, 0);
    checkVal({tag, "_flags"}, ovFlagsOut, 0);
    checkVal({tag, "_resvalid"}, oResValid, 0);
    checkVal({tag, "_issued"}, ovIssued, 0);
    checkVal({tag, "_cmdready"}, oCmdReady, 0);
  endtask

  // Sole driver of the result-side backpressure.
  initial begin
    iResReady = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      iResReady = (readyMode == 2) ? 1'($urandom) : (readyMode == 1);
    end
  end

  // Every cycle a result is presented it must match the model head; the head retires on handshake.
  always @(negedge iClk) begin
    if (iReset_n === 1'b1 && oResValid) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_result", oResValid, 0);
      end else begin
        checkVal("res", ovResult, expQ[0].res);
        checkVal("flags", ovFlagsOut, expQ[0].flags);
        checkVal("opcode", ovInstruccion, expQ[0].op);
        checkVal("operandA", ovRegistroA, expQ[0].a);
        checkVal("operandB", ovRegistroB, expQ[0].b);
        if (iResReady) begin
          checkVal("issued", ovIssued, issuedModel);
          $display("result op=%0h a=%0h b=%0h -> res=%0h flags=%0h issued=%0d",
                   ovInstruccion, ovRegistroA, ovRegistroB, ovResult, ovFlagsOut, ovIssued);
          issuedModel++;
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [3:0] r, f;
    logic [7:0] issuedBase;
    iReset_n    = 1'b0;
    iCmdValid   = 1'b0;
    ivCmd       = '0;
    readyMode   = 0;
    prevRes     = '0;
    issuedModel = '0;
    repeat (3) @(negedge iClk);
    checkResetOutputs("por");
    readyMode = 1;
    #2 iReset_n = 1'b1;
    @(negedge iClk);
    checkVal("ready_after_reset", oCmdReady, 1);
    checkVal("valid_after_reset", oResValid, 0);

    // Latency and basic add
    pushCmd(13'h0034);
    lat = 0;
    while (!oResValid && lat < 20) begin
      @(negedge iClk);
      lat++;
    end
    checkVal("latency", lat, 3);
    checkVal("t1_res", ovResult, 4'h7);
    checkVal("t1_flags", ovFlagsOut, 4'h0);
    @(negedge iClk);
    checkVal("t1_issued", ovIssued, 1);

    // Carry out
    pushCmd(13'h00F2);
    waitResult(r, f);
    checkVal("t2_res", r, 4'h1);
    checkVal("t2_flags", f, 4'h1);
    drain();

    // Backpressure: four FIFO entries plus one held in DONE
    readyMode = 0;
    repeat (2) @(negedge iClk);
    issuedBase = issuedModel;
    for (int i = 0; i < 4; i++) pushCmd(13'($urandom));
    checkVal("bp_ready_after4", oCmdReady, 1);
    pushCmd(13'($urandom));
    checkVal("bp_ready_after5", oCmdReady, 0);
    checkVal("bp_first_valid", oResValid, 1);
    checkVal("bp_first_res", ovResult, expQ[0].res);
    repeat (4) @(negedge iClk);
    checkVal("bp_still_full", oCmdReady, 0);
    readyMode = 1;
    drain();
    checkVal("bp_issued", ovIssued, issuedBase + 8'd5);

    // Chained accumulate
    pushCmd(13'h0123);
    pushCmd(13'h1194);
    waitResult(r, f);
    checkVal("chain_first", r, 4'h5);
    waitResult(r, f);
    checkVal("chain_second", r, CHAIN ? 4'h9 : 4'hD);
    drain();

    // Randomized commands with random backpressure
    readyMode = 2;
    for (int i = 0; i < 60; i++) pushCmd(13'($urandom));
    drain();

    // Reset during EXEC with two commands queued
    readyMode = 0;
    repeat (2) @(negedge iClk);
    for (int i = 0; i < 3; i++) pushCmd(13'($urandom) & 13'h0FFF);
    #2 iReset_n = 1'b0;
    expQ.delete();
    prevRes     = '0;
    issuedModel = '0;
    #1 checkResetOutputs("midop");
    @(negedge iClk);
    #2 iReset_n = 1'b1;
    readyMode = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      checkVal("no_result_after_reset", oResValid, 0);
    end

    // Handshake counter wrap
    for (int i = 0; i < 255; i++) pushCmd(13'($urandom));
    drain();
    checkVal("issued_255", ovIssued, 8'd255);
    pushCmd(13'($urandom));
    drain();
    checkVal("issued_wrap", ovIssued, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
